sdram_host_responder: RTL
=========================

// Module: sdram_host_responder
// PURPOSE
//  Responder end of the SDRAM host handshake used by the cache and bypass paths.
//  Accepts sdram_rd/sdram_wr requests and models SDRAM row, CAS and refresh timing.
//  Backs the data with an internal 16-bit word array.
//  Used as the memory side in simulation and on boards without SDRAM.
// PARAMETERS
//  MEM_AW           12   word-array address bits; index = sdram_haddr[MEM_AW-1:0] (upper bits alias)
//  COL_BITS         8    column bits; row = sdram_haddr[23:COL_BITS]
//  CAS_LATENCY      2    cycles from opbegun cycle to rddone cycle (1..7)
//  T_RCD            2    activate-to-accept cycles
//  T_RP             2    precharge cycles
//  T_WR             2    cycles from write opbegun cycle to done cycle (1..7)
//  REFRESH_INTERVAL 390  cycles between refresh requests
//  T_RFC            7    refresh duration, cycles
// PORTS
//  clock             in   1   rising-edge clock
//  reset             in   1   asynchronous, active-high
//  sdram_rd          in   1   read request, held by host until opbegun
//  sdram_wr          in   1   write request, held by host until opbegun
//  sdram_haddr       in   24  word address
//  sdram_hdin        in   16  write data
//  sdram_hdout       out  16  read data, valid in the rddone cycle
//  sdram_earlyopbegun out 1   combinational; high in the cycle whose closing edge accepts a request
//  sdram_opbegun     out  1   registered one-cycle pulse following the accept edge
//  sdram_rdpending   out  1   accepted reads not yet returned
//  sdram_done        out  1   one-cycle pulse: write committed
//  sdram_rddone      out  1   one-cycle pulse: read data on sdram_hdout
//  refreshing        out  1   high while in PRECHARGE/REFRESH for a refresh
// BEHAVIOUR
//  Reset:
//   - all outputs 0; FSM -> IDLE; no open row.
//   - read pipeline and write-recovery counters cleared; refresh counter = 0.
//   - Array contents are not cleared.
//  Request decode:
//   - req = sdram_rd | sdram_wr. If both are high, the request is a read and wr is ignored.
//  Accept rule:
//   - Accept occurs at edge E when state==ACTIVE, req=1, the row matches the open row,
//     and no refresh is pending.
//   - earlyopbegun is high in the cycle before E.
//   - At E: address/data are sampled; a write updates the array at E.
//   - opbegun is high for the cycle after E.
//   - A request may not be accepted in an opbegun cycle (host still shows the old request),
//     so the maximum rate is one accept per 2 cycles.
//  Reads:
//   - Data is captured at E into a CAS_LATENCY-deep pipeline.
//   - rddone and hdout are presented CAS_LATENCY cycles after the opbegun cycle.
//   - rdpending is high from the opbegun cycle until and including the last rddone cycle.
//   - A write then a read to the same word returns the new data.
//  Writes:
//   - done pulses T_WR cycles after the opbegun cycle; write-recovery count = T_WR.
//  FSM:
//   - IDLE -> ACT_WAIT on req or refresh pending (refresh: -> REFRESH directly).
//   - ACT_WAIT: T_RCD cycles, opens row(haddr), -> ACTIVE.
//   - ACTIVE: accept as above, -> ACK; row miss or refresh pending -> DRAIN.
//   - ACK: 1 cycle, -> ACTIVE.
//   - DRAIN: wait until read pipeline empty and write recovery expired, -> PRECHARGE.
//   - PRECHARGE: T_RP cycles, closes row; -> REFRESH if refresh pending, else IDLE.
//   - REFRESH: T_RFC cycles, clears pending, -> IDLE.
//  Refresh:
//   - The counter wraps at REFRESH_INTERVAL-1 and sets pending.
//   - Pending stays set until serviced; a second wrap while pending is lost (not queued).
//   - Pending never aborts an accepted op; it takes priority over a new accept in the same cycle.
//  Request dropped before opbegun: FSM stays in ACTIVE; no opbegun.
//  Reset mid-op: in-flight rddone/done pulses are discarded.
// TESTING
//  - Idle read: reset, write 0xBEEF to 0x000123, then read 0x000123.
//    -> rddone exactly CAS_LATENCY cycles after its opbegun; hdout = 0xBEEF.
//  - Burst: host reload pattern, 16 reads 0x000120..0x00012F, address incremented on each opbegun.
//    -> 16 rddone pulses in order, accepts exactly 2 cycles apart, rdpending low after the 16th.
//  - Row miss: read 0x000010 then 0x000310 (different row).
//    -> second earlyopbegun only after pipeline drain + T_RP + T_RCD; data correct.
//  - Refresh collision: assert rd on the cycle the refresh counter wraps.
//    -> refreshing=1 for T_RP+T_RFC cycles before accept; no opbegun while refreshing.
//  - rd+wr together at 0x000040 with hdin=0x1111.
//    -> handled as read: no done, array word unchanged.
//  - Reset asserted 1 cycle after a read opbegun.
//    -> no rddone ever; all outputs 0; next read costs T_RCD from IDLE.

Source files
------------

// File: rtl/sdram_host_responder.sv
// SDRAM host handshake responder backed by a word array.
// Models row open/close, CAS latency, write recovery and refresh.
module sdram_host_responder #(
   parameter int MEM_AW           = 12,
   parameter int COL_BITS         = 8,
   parameter int CAS_LATENCY      = 2,
   parameter int T_RCD            = 2,
   parameter int T_RP             = 2,
   parameter int T_WR             = 2,
   parameter int REFRESH_INTERVAL = 390,
   parameter int T_RFC            = 7
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        sdram_rd,
   input  logic        sdram_wr,
   input  logic [23:0] sdram_haddr,
   input  logic [15:0] sdram_hdin,
   output logic [15:0] sdram_hdout,
   output logic        sdram_earlyopbegun,
   output logic        sdram_opbegun,
   output logic        sdram_rdpending,
   output logic        sdram_done,
   output logic        sdram_rddone,
   output logic        refreshing
);

   typedef enum logic [2:0] {
      IDLE, ACT_WAIT, ACTIVE, ACK, DRAIN, PRECHARGE, REFRESH
   } state_t;

   localparam int RW    = 24 - COL_BITS;
   localparam int REF_W = $clog2(REFRESH_INTERVAL);

   state_t             state, state_n;
   logic [7:0]         tcnt;
   logic [RW-1:0]      open_row;
   logic               row_open;
   logic [REF_W-1:0]   ref_cnt;
   logic               ref_pending;
   logic               ref_wrap;
   logic [CAS_LATENCY:0] rd_v;
   logic [T_WR:0]      wr_v;
   logic [15:0]        rd_d [CAS_LATENCY+1];
   logic [15:0]        mem [0:(1<<MEM_AW)-1];
   logic               req, is_rd, row_hit;
   logic               accept, acc_rd, acc_wr;
   logic               pipe_busy;
   logic [MEM_AW-1:0]  idx;

   assign req       = sdram_rd | sdram_wr;
   assign is_rd     = sdram_rd;
   assign idx       = sdram_haddr[MEM_AW-1:0];
   assign row_hit   = row_open
                    && (open_row == sdram_haddr[23:COL_BITS]);
   assign pipe_busy = (|rd_v) | (|wr_v);
   assign ref_wrap  = (ref_cnt == REF_W'(REFRESH_INTERVAL-1));
   assign acc_rd    = accept & is_rd;
   assign acc_wr    = accept & ~is_rd;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         tcnt     <= '0;
         open_row <= '0;
         row_open <= 1'b0;
      end else begin
         state <= state_n;
         tcnt  <= (state_n != state) ? 8'd0 : tcnt + 8'd1;
         if (state == IDLE && state_n == ACT_WAIT)
            open_row <= sdram_haddr[23:COL_BITS];
         if (state == ACT_WAIT && state_n == ACTIVE)
            row_open <= 1'b1;
         if (state == PRECHARGE && state_n != PRECHARGE)
            row_open <= 1'b0;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:
            if (ref_pending)  state_n = REFRESH;
            else if (req)     state_n = ACT_WAIT;
         ACT_WAIT:
            if (tcnt == 8'(T_RCD-1)) state_n = ACTIVE;
         ACTIVE:
            if (accept)
               state_n = ACK;
            else if (ref_pending || (req && !row_hit))
               state_n = DRAIN;
         ACK:
            state_n = ACTIVE;
         DRAIN:
            if (!pipe_busy) state_n = PRECHARGE;
         PRECHARGE:
            if (tcnt == 8'(T_RP-1))
               state_n = ref_pending ? REFRESH : IDLE;
         REFRESH:
            if (tcnt == 8'(T_RFC-1)) state_n = IDLE;
         default:
            state_n = IDLE;
      endcase
   end

   // Refresh pending wins over a same-cycle accept.
   always_comb begin
      accept = (state == ACTIVE) && req && row_hit && !ref_pending;
      sdram_earlyopbegun = accept;
      refreshing = (state == REFRESH)
                 || (state == PRECHARGE && ref_pending);
      sdram_rdpending = |rd_v;
      sdram_rddone    = rd_v[CAS_LATENCY];
      sdram_done      = wr_v[T_WR];
      sdram_hdout     = rd_v[CAS_LATENCY] ? rd_d[CAS_LATENCY] : 16'h0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sdram_opbegun <= 1'b0;
         rd_v          <= '0;
         wr_v          <= '0;
         ref_cnt       <= '0;
         ref_pending   <= 1'b0;
      end else begin
         sdram_opbegun <= accept;
         rd_v <= {rd_v[CAS_LATENCY-1:0], acc_rd};
         wr_v <= {wr_v[T_WR-1:0], acc_wr};
         ref_cnt <= ref_wrap ? '0 : ref_cnt + REF_W'(1);
         if (state == REFRESH && state_n == IDLE)
            ref_pending <= 1'b0;
         if (ref_wrap)
            ref_pending <= 1'b1;
      end
   end

   // Array and data pipeline are deliberately not reset.
   always_ff @(posedge clock) begin
      if (acc_wr)
         mem[idx] <= sdram_hdin;
      if (acc_rd)
         rd_d[0] <= mem[idx];
      for (int i = 1; i <= CAS_LATENCY; i++)
         rd_d[i] <= rd_d[i-1];
   end

endmodule
